// File: rtl/pic_cmd_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between three framed command sources.
// Frames of up to five bytes are sent MSB-byte-first, with a timeout and an inter-frame gap.
module pic_cmd_arbiter #(
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned TX_TIMEOUT = 4095
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  req,
  input  logic [39:0] frame0,
  input  logic [39:0] frame1,
  input  logic [39:0] frame2,
  input  logic [2:0]  len0,
  input  logic [2:0]  len1,
  input  logic [2:0]  len2,
  output logic [2:0]  ack,
  output logic [2:0]  err,
  output logic        busy,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  input  logic        tx_active,
  input  logic        tx_done,
  output logic        timeout_flag
);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWaitDone, StGap} state_e;

  localparam logic [11:0] TmoLimit = 12'(TX_TIMEOUT);
  localparam logic [15:0] GapLast  = 16'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [39:0] sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  g_q, g_d;
  logic [1:0]  last_q, last_d;
  logic [11:0] tmo_q, tmo_d;
  logic [15:0] gap_q, gap_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [2:0]  ack_q, ack_d;
  logic [2:0]  err_q, err_d;
  logic        flag_q, flag_d;

  logic [1:0]  c0, c1, win;
  logic [39:0] win_frame;
  logic [2:0]  win_len, win_len_c;
  logic [11:0] tmo_inc;

  function automatic logic [1:0] nxt(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Scan last+1, last+2, last (mod 3); only used when req is nonzero.
  always_comb begin
    c0 = nxt(last_q);
    c1 = nxt(c0);
    if (req[c0])      win = c0;
    else if (req[c1]) win = c1;
    else              win = last_q;
  end

  always_comb begin
    unique case (win)
      2'd1:    begin win_frame = frame1; win_len = len1; end
      2'd2:    begin win_frame = frame2; win_len = len2; end
      default: begin win_frame = frame0; win_len = len0; end
    endcase
    win_len_c = (win_len > 3'd5) ? 3'd5 : win_len;
  end

  assign tmo_inc = tmo_q + 12'd1;

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    g_d        = g_q;
    last_d     = last_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    ack_d      = 3'b000;
    err_d      = 3'b000;
    flag_d     = flag_q;

    unique case (state_q)
      StIdle: begin
        if (req != 3'b000) begin
          g_d  = win;
          sh_d = win_frame;
          if (win_len_c == 3'd0) begin
            ack_d  = 3'b001 << win;
            last_d = win;
          end else begin
            cnt_d   = win_len_c;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        tx_byte_d  = sh_q[39:32];
        sh_d       = {sh_q[31:0], 8'h00};
        cnt_d      = cnt_q - 3'd1;
        tmo_d      = '0;
        tx_start_d = 1'b1;
        state_d    = StStart;
      end
      StStart: begin
        if (tx_active) begin
          tmo_d   = '0;
          state_d = StWaitDone;
        end else if (tmo_inc == TmoLimit) begin
          err_d   = 3'b001 << g_q;
          flag_d  = 1'b1;
          last_d  = g_q;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
        end else begin
          tmo_d      = tmo_inc;
          tx_start_d = 1'b1;
        end
      end
      StWaitDone: begin
        if (tx_done) begin
          if (cnt_q != 3'd0) begin
            state_d = StLoad;
          end else begin
            ack_d   = 3'b001 << g_q;
            last_d  = g_q;
            gap_d   = '0;
            state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
          end
        end else if (tmo_inc == TmoLimit) begin
          err_d   = 3'b001 << g_q;
          flag_d  = 1'b1;
          last_d  = g_q;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      StGap: begin
        if (gap_q == GapLast) state_d = StIdle;
        else                  gap_d   = gap_q + 16'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      sh_q       <= '0;
      cnt_q      <= '0;
      g_q        <= 2'd0;
      last_q     <= 2'd2;
      tmo_q      <= '0;
      gap_q      <= '0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      ack_q      <= 3'b000;
      err_q      <= 3'b000;
      flag_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      g_q        <= g_d;
      last_q     <= last_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      flag_q     <= flag_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign tx_start     = tx_start_q;
  assign tx_byte      = tx_byte_q;
  assign ack          = ack_q;
  assign err          = err_q;
  assign timeout_flag = flag_q;

endmodule

// File: tb/tb_pic_cmd_arbiter.sv
// Directed bench for pic_cmd_arbiter with a small uart_tx responder model.
module tb_pic_cmd_arbiter;

  localparam int unsigned Gap = 4;
  localparam int unsigned Tmo = 20;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [39:0] frame0 = '0, frame1 = '0, frame2 = '0;
  logic [2:0]  len0 = '0, len1 = '0, len2 = '0;
  logic [2:0]  ack, err;
  logic        busy, tx_start, timeout_flag;
  logic [7:0]  tx_byte;
  logic        tx_active = 1'b0;
  logic        tx_done = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] byte_q[$];
  int         ack_cyc[$];
  int         idle_cyc[$];
  int         cyc = 0;
  int         err_cnt = 0;
  logic       busy_prev = 1'b0;
  logic       model_en = 1'b1;
  logic       m_busy = 1'b0;
  int         m_cnt = 0;

  pic_cmd_arbiter #(.GAP_CYCLES(Gap), .TX_TIMEOUT(Tmo)) dut (
    .clock(clock), .reset_n(reset_n), .req(req),
    .frame0(frame0), .frame1(frame1), .frame2(frame2),
    .len0(len0), .len1(len1), .len2(len2),
    .ack(ack), .err(err), .busy(busy),
    .tx_start(tx_start), .tx_byte(tx_byte),
    .tx_active(tx_active), .tx_done(tx_done),
    .timeout_flag(timeout_flag)
  );

  always #5 clock = ~clock;

  // uart_tx stand-in: accepts a byte, stays active a few cycles, then pulses done.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      tx_done = 1'b0;
      if (!reset_n) begin
        tx_active = 1'b0;
        m_busy = 1'b0;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          tx_active = 1'b0;
          tx_done = 1'b1;
          m_busy = 1'b0;
        end else begin
          m_cnt--;
        end
      end else if (model_en && tx_start) begin
        byte_q.push_back(tx_byte);
        tx_active = 1'b1;
        m_busy = 1'b1;
        m_cnt = 2;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (ack != 3'b000) ack_cyc.push_back(cyc);
      if (err != 3'b000) err_cnt++;
      if (!busy && busy_prev) idle_cyc.push_back(cyc);
      busy_prev = busy;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output logic [2:0] a, output int n);
    a = 3'b000;
    n = 0;
    while (n < 400) begin
      @(negedge clock);
      n++;
      if (ack != 3'b000) begin
        a = ack;
        return;
      end
    end
  endtask

  task automatic wait_bytes(input int k);
    for (int i = 0; i < 400; i++) begin
      if (byte_q.size() >= k) return;
      @(negedge clock);
    end
  endtask

  initial begin
    logic [2:0] a;
    int         n;
    logic [7:0] exp5[5];
    logic [2:0] rr_exp[6];

    repeat (3) @(negedge clock);
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ack_err", 64'({ack, err}), 64'd0);
    check("rst_tx_byte", 64'(tx_byte), 64'h00);
    check("rst_flag", 64'(timeout_flag), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Single five-byte frame, plus grant latency.
    frame0 = 40'h03C0A8010A;
    len0 = 3'd5;
    req = 3'b001;
    n = 0;
    while (!tx_start && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("grant_latency", 64'(n), 64'd2);
    wait_ack(a, n);
    req = 3'b000;
    check("single_ack", 64'(a), 64'b001);
    exp5 = '{8'h03, 8'hC0, 8'hA8, 8'h01, 8'h0A};
    check("single_nbytes", 64'(byte_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) check($sformatf("single_byte%0d", i), 64'(byte_q[i]), 64'(exp5[i]));
    check("single_no_err", 64'(err_cnt), 64'd0);
    repeat (Gap + 2) @(negedge clock);

    // Round-robin: last granted was 0.
    byte_q.delete();
    ack_cyc.delete();
    idle_cyc.delete();
    frame0 = 40'hA000000000;
    frame1 = 40'hA100000000;
    frame2 = 40'hA200000000;
    len0 = 3'd1;
    len1 = 3'd1;
    len2 = 3'd1;
    rr_exp = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      wait_ack(a, n);
      if (i == 5) req = 3'b000;
      check($sformatf("rr_ack%0d", i), 64'(a), 64'(rr_exp[i]));
    end
    repeat (Gap + 2) @(negedge clock);
    check("rr_first_byte", 64'(byte_q[0]), 64'hA1);
    check("rr_third_byte", 64'(byte_q[2]), 64'hA0);
    for (int i = 0; i < 6; i++)
      check($sformatf("rr_gap%0d", i), 64'(idle_cyc[i] - ack_cyc[i]), 64'(Gap));

    // Zero-length frame on source 1, then clamp on source 2.
    byte_q.delete();
    len1 = 3'd0;
    req = 3'b010;
    wait_ack(a, n);
    req = 3'b000;
    check("zero_ack", 64'(a), 64'b010);
    check("zero_latency", 64'(n), 64'd1);
    repeat (3) @(negedge clock);
    check("zero_no_bytes", 64'(byte_q.size()), 64'd0);

    frame2 = 40'h1122334455;
    len2 = 3'd7;
    req = 3'b100;
    wait_ack(a, n);
    req = 3'b000;
    check("clamp_ack", 64'(a), 64'b100);
    check("clamp_nbytes", 64'(byte_q.size()), 64'd5);
    check("clamp_last", 64'(byte_q[4]), 64'h55);
    repeat (Gap + 2) @(negedge clock);

    // Timeout: responder silent.
    model_en = 1'b0;
    req = 3'b001;
    n = 0;
    while (!tx_start && n < 20) begin
      @(negedge clock);
      n++;
    end
    n = 0;
    while (tx_start && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("tmo_start_cycles", 64'(n), 64'(Tmo));
    check("tmo_err", 64'(err), 64'b001);
    check("tmo_ack_clear", 64'(ack), 64'b000);
    check("tmo_flag", 64'(timeout_flag), 64'd1);
    model_en = 1'b1;
    byte_q.delete();
    frame1 = 40'h7700000000;
    len1 = 3'd1;
    req = 3'b010;
    wait_ack(a, n);
    req = 3'b000;
    check("tmo_next_ack", 64'(a), 64'b010);
    check("tmo_next_byte", 64'(byte_q[0]), 64'h77);
    check("tmo_err_count", 64'(err_cnt), 64'd1);
    repeat (Gap + 2) @(negedge clock);

    // Inputs change mid-frame.
    byte_q.delete();
    frame0 = 40'h5A6B7C0000;
    len0 = 3'd3;
    req = 3'b001;
    wait_bytes(2);
    frame0 = 40'hFFFFFFFFFF;
    req = 3'b000;
    wait_ack(a, n);
    check("chg_ack", 64'(a), 64'b001);
    check("chg_nbytes", 64'(byte_q.size()), 64'd3);
    check("chg_byte1", 64'(byte_q[1]), 64'h6B);
    check("chg_byte2", 64'(byte_q[2]), 64'h7C);
    repeat (Gap + 2) @(negedge clock);

    // Reset during the third byte.
    byte_q.delete();
    frame0 = 40'h1020304050;
    len0 = 3'd5;
    req = 3'b001;
    wait_bytes(3);
    @(negedge clock);
    check("pre_rst_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_tx_start", 64'(tx_start), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ack_err", 64'({ack, err}), 64'd0);
    check("mid_rst_flag", 64'(timeout_flag), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    len1 = 3'd1;
    len0 = 3'd1;
    req = 3'b011;
    wait_ack(a, n);
    req = 3'b010;
    check("post_rst_first", 64'(a), 64'b001);
    wait_ack(a, n);
    req = 3'b000;
    check("post_rst_second", 64'(a), 64'b010);
    repeat (Gap + 2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
